// File: rtl/dram_ctrl.sv
// Data-memory controller: owns the data RAM, clears it after reset, accepts host
// preloads and serves processor reads/writes over a req/done handshake.
module dram_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAT_W = $clog2(READ_LAT + 1);
  localparam int unsigned CMP_W = ADDR_W + 1;

  typedef enum logic [1:0] {INIT, IDLE, WR, RD} state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              accept;
  logic              cpu_ok;
  logic              ld_ok;

  // Range check is done on the full address before it is truncated to an index.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < CMP_W'(DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a);
  endfunction

  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
    return in_range(a) ? mem[to_idx(a)] : '0;
  endfunction

  assign cpu_ok = in_range(cpu_addr);
  assign ld_ok  = in_range(ld_addr);
  assign accept = (state == IDLE) && !ld_en && cpu_req;

  // Single array write port shared by clear, preload and CPU write; preload wins.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state)
        INIT: begin
          mem_we    = 1'b1;
          mem_waddr = clr_cnt;
        end
        IDLE: begin
          if (ld_en) begin
            mem_we    = ld_ok;
            mem_waddr = to_idx(ld_addr);
            mem_wdata = ld_data;
          end else if (cpu_req && cpu_we) begin
            mem_we    = cpu_ok;
            mem_waddr = to_idx(cpu_addr);
            mem_wdata = cpu_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control FSM; done/err/rdata/busy are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      clr_cnt   <= '0;
      lat_cnt   <= '0;
      addr_q    <= '0;
      busy      <= 1'b1;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (accept) begin
            addr_q <= cpu_addr;
            busy   <= 1'b1;
            if (cpu_we) begin
              state    <= WR;
              cpu_done <= 1'b1;
              cpu_err  <= !cpu_ok;
            end else begin
              state   <= RD;
              lat_cnt <= LAT_W'(READ_LAT - 1);
              // Single-cycle latency completes straight out of the accept edge.
              if (READ_LAT == 1) begin
                cpu_done  <= 1'b1;
                cpu_err   <= !cpu_ok;
                cpu_rdata <= rd_word(cpu_addr);
              end
            end
          end
        end
        WR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        RD: begin
          if (lat_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
            if (lat_cnt == LAT_W'(1)) begin
              cpu_done  <= 1'b1;
              cpu_err   <= !in_range(addr_q);
              cpu_rdata <= rd_word(addr_q);
            end
          end
        end
        default: begin
          state <= INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl: a DEPTH=16/READ_LAT=2 instance driven from a
// vector table plus corner sequences, and a READ_LAT=1 instance.
module tb_dram_ctrl;

  logic        clk;
  logic        rst, cpu_req, cpu_we, ld_en;
  logic [11:0] cpu_addr, ld_addr;
  logic [31:0] cpu_wdata, ld_data, cpu_rdata;
  logic        cpu_done, cpu_err, busy;

  logic        b_rst, b_req, b_we, b_ld_en;
  logic [11:0] b_addr, b_ld_addr;
  logic [31:0] b_wdata, b_ld_data, b_rdata;
  logic        b_done, b_err, b_busy;

  int total;
  int bad;

  dram_ctrl #(.DATA_W(32), .ADDR_W(12), .DEPTH(16), .READ_LAT(2)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .busy(busy), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  dram_ctrl #(.DATA_W(32), .ADDR_W(12), .DEPTH(16), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(b_rst), .cpu_req(b_req), .cpu_we(b_we), .cpu_addr(b_addr),
    .cpu_wdata(b_wdata), .cpu_rdata(b_rdata), .cpu_done(b_done), .cpu_err(b_err),
    .busy(b_busy), .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete handshake on the READ_LAT=2 instance with latency/err/rdata checks.
  task automatic op_a(input logic we, input logic [11:0] a, input logic [31:0] d,
                      input int lat, input logic [31:0] exp_rd, input logic exp_err,
                      input string nm);
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk({nm, " idle"}, 32'(busy), 32'd0);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_done && n < 20);
    cpu_req = 1'b0;
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " err"}, 32'(cpu_err), 32'(exp_err));
    chk({nm, " rdata"}, cpu_rdata, exp_rd);
    tick();
    chk({nm, " done_pulse"}, 32'(cpu_done), 32'd0);
  endtask

  // Counts busy cycles after a reset edge and notes any stray completion.
  task automatic init_len(input string nm);
    int  n;
    logic saw;
    n   = 0;
    saw = 1'b0;
    while (busy && n < 100) begin
      n++;
      if (cpu_done) saw = 1'b1;
      tick();
    end
    chk({nm, " busy_cycles"}, 32'(n), 32'd16);
    chk({nm, " no_done"}, 32'(saw), 32'd0);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    b_rst = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0;

    vecs[0] = '{1'b1, 12'd5,    32'hDEADBEEF, 1, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 12'd5,    32'h0,        2, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 12'd6,    32'h11111111, 1, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b0, 12'd6,    32'h0,        2, 32'h11111111, 1'b0};
    vecs[4] = '{1'b0, 12'd20,   32'h0,        2, 32'h00000000, 1'b1};
    vecs[5] = '{1'b1, 12'd20,   32'hCAFEF00D, 1, 32'h00000000, 1'b1};
    vecs[6] = '{1'b0, 12'd4,    32'h0,        2, 32'h00000000, 1'b0};
    vecs[7] = '{1'b1, 12'd15,   32'hA5A5A5A5, 1, 32'h00000000, 1'b0};
    vecs[8] = '{1'b0, 12'd15,   32'h0,        2, 32'hA5A5A5A5, 1'b0};
    vecs[9] = '{1'b0, 12'd4095, 32'h0,        2, 32'h00000000, 1'b1};

    repeat (3) tick();
    rst   = 1'b0;
    b_rst = 1'b0;
    chk("rst busy",  32'(busy),     32'd1);
    chk("rst done",  32'(cpu_done), 32'd0);
    chk("rst err",   32'(cpu_err),  32'd0);
    chk("rst rdata", cpu_rdata,     32'd0);
    init_len("init");

    for (int i = 0; i < 16; i++)
      op_a(1'b0, 12'(i), 32'h0, 2, 32'h0, 1'b0, $sformatf("clr_rd%0d", i));

    for (int i = 0; i < 10; i++)
      op_a(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].rdata,
           vecs[i].err, $sformatf("vec%0d", i));

    // Preload collides with a CPU write to the same address.
    ld_en = 1'b1; ld_addr = 12'd3; ld_data = 32'h12345678;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd3; cpu_wdata = 32'hAAAAAAAA;
    tick();
    chk("ld_prio done", 32'(cpu_done), 32'd0);
    chk("ld_prio busy", 32'(busy),     32'd0);
    ld_en = 1'b0;
    tick();
    chk("ld_prio wr_done", 32'(cpu_done), 32'd1);
    cpu_req = 1'b0;
    tick();
    op_a(1'b0, 12'd3, 32'h0, 2, 32'hAAAAAAAA, 1'b0, "ld_prio rd3");

    // Preload immediately followed by a read of the same word.
    ld_en = 1'b1; ld_addr = 12'd7; ld_data = 32'h77777777;
    tick();
    ld_en = 1'b0;
    op_a(1'b0, 12'd7, 32'h0, 2, 32'h77777777, 1'b0, "ld_then_rd7");

    // Reset in the middle of a read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd5;
    tick();
    chk("midrd accepted busy", 32'(busy),     32'd1);
    chk("midrd early done",    32'(cpu_done), 32'd0);
    rst = 1'b1;
    cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrd done",  32'(cpu_done), 32'd0);
    chk("midrd rdata", cpu_rdata,     32'd0);
    chk("midrd busy",  32'(busy),     32'd1);
    init_len("reinit");
    op_a(1'b0, 12'd5, 32'h0, 2, 32'h0, 1'b0, "reinit rd5");

    // READ_LAT=1 instance: preloads during INIT are dropped.
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    repeat (4) tick();
    b_ld_en = 1'b1; b_ld_addr = 12'd1; b_ld_data = 32'h99999999;
    repeat (6) tick();
    b_ld_en = 1'b0;
    n = 0;
    while (b_busy && n < 50) begin
      tick();
      n++;
    end
    chk("l1 init_end", 32'(b_busy), 32'd0);
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'd0; b_wdata = 32'h00000001;
    tick();
    chk("l1 wr done", 32'(b_done), 32'd1);
    b_req = 1'b0;
    tick();
    chk("l1 wr pulse", 32'(b_done), 32'd0);
    chk("l1 wr busy",  32'(b_busy), 32'd0);
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'd0;
    tick();
    chk("l1 rd0 done",  32'(b_done), 32'd1);
    chk("l1 rd0 rdata", b_rdata,     32'h00000001);
    chk("l1 rd0 err",   32'(b_err),  32'd0);
    b_req = 1'b0;
    tick();
    chk("l1 rd0 pulse", 32'(b_done), 32'd0);
    b_req = 1'b1; b_addr = 12'd1;
    tick();
    chk("l1 rd1 done",  32'(b_done), 32'd1);
    chk("l1 rd1 rdata", b_rdata,     32'h0);
    b_req = 1'b0;
    tick();
    b_req = 1'b1; b_addr = 12'd20;
    tick();
    chk("l1 rd20 done",  32'(b_done), 32'd1);
    chk("l1 rd20 err",   32'(b_err),  32'd1);
    chk("l1 rd20 rdata", b_rdata,     32'h0);
    b_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
